risc_test_sequencer: RTL and testbench

RISC_TEST_SEQUENCER -- requirements
Module: risc_test_sequencer

---
 rtl/risc_test_sequencer.sv | 142 ++++++++++++++
 tb/tb_risc_test_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_test_sequencer.sv
// Purpose: loads a program into imem, holds the core in reset, runs it and scores write-backs against an expected stream.
// Latency: one imem write per accepted beat, compare in the same cycle as exp_valid; status flags registered.
// Backpressure: src_ready only in LOAD, exp_ready only in RUN. Optional trace outputs: RISC_TEST_SEQ_TRACE_EN.
module risc_test_sequencer #(
    parameter int XLEN        = 32,
    parameter int IMEM_AW     = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [IMEM_AW:0]   prog_len,
    input  logic [15:0]        chk_len,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [XLEN-1:0]    src_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               cpu_reset,
    input  logic [XLEN-1:0]    wb_out,
    input  logic               exp_valid,
    output logic               exp_ready,
    input  logic [XLEN-1:0]    exp_data,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [15:0]        err_count,
    output logic [15:0]        cycle_count
`ifdef RISC_TEST_SEQ_TRACE_EN
    ,
    output logic [15:0]        first_fail_idx,
    output logic [XLEN-1:0]    first_fail_data
`endif
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
    localparam logic [IMEM_AW:0] MAX_LEN   = {1'b1, {IMEM_AW{1'b0}}};
    localparam logic [IMEM_AW:0] LEN_ONE   = {{IMEM_AW{1'b0}}, 1'b1};
    localparam logic [15:0]      TIMEOUT_W = 16'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [IMEM_AW:0]   load_idx, load_len, len_in;
    logic [HW-1:0]      hold_cnt;
    logic [15:0]        chk_len_q, cmp_count;
    logic               timeout_q;
    logic               start_ok, beat, cmp_fire, mismatch, last_cmp, tmo_hit;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign len_in   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign beat     = (state == S_LOAD) && src_valid;
    assign cmp_fire = (state == S_RUN) && exp_valid;
    assign mismatch = cmp_fire && (wb_out != exp_data);
    assign last_cmp = cmp_fire && ((cmp_count + 16'd1) == chk_len_q);
    // Final compare wins over a coincident timeout.
    assign tmo_hit  = ((cycle_count + 16'd1) == TIMEOUT_W) && (chk_len_q != 16'd0) && !last_cmp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = (len_in != '0) ? S_LOAD : S_HOLD;
            S_LOAD:         if (beat && (load_idx + LEN_ONE) == load_len) state_nxt = S_HOLD;
            S_HOLD:         if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            S_RUN:          if ((chk_len_q == 16'd0) || last_cmp || tmo_hit) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_idx    <= '0;
            load_len    <= '0;
            hold_cnt    <= '0;
            chk_len_q   <= '0;
            cmp_count   <= '0;
            err_count   <= '0;
            cycle_count <= '0;
            timeout_q   <= 1'b0;
        end else if (start_ok) begin
            load_idx    <= '0;
            load_len    <= len_in;
            hold_cnt    <= '0;
            chk_len_q   <= chk_len;
            cmp_count   <= '0;
            err_count   <= '0;
            cycle_count <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (beat) load_idx <= load_idx + LEN_ONE;
            if (state == S_HOLD) hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + HOLD_ONE;
            if (state == S_RUN) begin
                cycle_count <= cycle_count + 16'd1;
                if (cmp_fire) cmp_count <= cmp_count + 16'd1;
                if (mismatch && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (tmo_hit) timeout_q <= 1'b1;
            end
        end
    end

`ifdef RISC_TEST_SEQ_TRACE_EN
    logic ff_cap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff_cap          <= 1'b0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
        end else if (start_ok) begin
            ff_cap          <= 1'b0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
        end else if (mismatch && !ff_cap) begin
            ff_cap          <= 1'b1;
            first_fail_idx  <= cmp_count;
            first_fail_data <= wb_out;
        end
    end
`endif

    assign src_ready  = (state == S_LOAD);
    assign imem_we    = beat;
    assign imem_addr  = load_idx[IMEM_AW-1:0];
    assign imem_wdata = beat ? src_data : '0;
    assign cpu_reset  = (state != S_RUN);
    assign exp_ready  = (state == S_RUN);
    assign busy       = (state == S_LOAD) || (state == S_HOLD) || (state == S_RUN);
    assign done       = (state == S_DONE);
    assign timeout    = timeout_q;
    assign pass       = done && (err_count == 16'd0) && !timeout_q;

endmodule

// File: tb/tb_risc_test_sequencer.sv
// Randomized bench for risc_test_sequencer with a transaction-level reference model and per-cycle output compare.
module tb_risc_test_sequencer;
    localparam int XLEN = 32;
    localparam int AW   = 4;
    localparam int HOLD = 2;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            reset, start, src_valid, exp_valid;
    logic [AW:0]     prog_len;
    logic [15:0]     chk_len;
    logic [XLEN-1:0] src_data, wb_out, exp_data;
    logic            src_ready, imem_we, cpu_reset, exp_ready, busy, done, pass, timeout;
    logic [AW-1:0]   imem_addr;
    logic [XLEN-1:0] imem_wdata;
    logic [15:0]     err_count, cycle_count;
`ifdef RISC_TEST_SEQ_TRACE_EN
    logic [15:0]     first_fail_idx;
    logic [XLEN-1:0] first_fail_data;
    logic [15:0]     m_ff_idx;
    logic [XLEN-1:0] m_ff_data;
    bit              m_ff_cap;
`endif

    always #5 clk = ~clk;

    risc_test_sequencer #(.XLEN(XLEN), .IMEM_AW(AW), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .chk_len(chk_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .wb_out(wb_out),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .cycle_count(cycle_count)
`ifdef RISC_TEST_SEQ_TRACE_EN
        , .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle, set by the driver from the sequencing rules.
    logic            m_src_ready, m_imem_we, m_cpu_reset, m_exp_ready, m_busy, m_done, m_pass, m_timeout;
    logic [AW-1:0]   m_imem_addr;
    logic [XLEN-1:0] m_imem_wdata;
    logic [15:0]     m_err, m_cyc;

    logic [XLEN-1:0] shadow [16];
    bit              written [16];
    int              wr_cnt = 0;
    int              dup_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_idle();
        m_src_ready = 0; m_imem_we = 0; m_imem_addr = '0; m_imem_wdata = '0;
        m_cpu_reset = 1; m_exp_ready = 0; m_busy = 0; m_done = 0; m_pass = 0;
        m_timeout = 0; m_err = '0; m_cyc = '0;
`ifdef RISC_TEST_SEQ_TRACE_EN
        m_ff_idx = '0; m_ff_data = '0; m_ff_cap = 0;
`endif
    endtask

    // Compare process plus imem write tracking.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("src_ready", src_ready, m_src_ready);
            check("imem_we", imem_we, m_imem_we);
            if (m_imem_we || !reset) begin
                check("imem_addr", imem_addr, m_imem_addr);
                check("imem_wdata", imem_wdata, m_imem_wdata);
            end
            check("cpu_reset", cpu_reset, m_cpu_reset);
            check("exp_ready", exp_ready, m_exp_ready);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("pass", pass, m_pass);
            check("timeout", timeout, m_timeout);
            check("err_count", err_count, m_err);
            check("cycle_count", cycle_count, m_cyc);
`ifdef RISC_TEST_SEQ_TRACE_EN
            check("first_fail_idx", first_fail_idx, m_ff_idx);
            check("first_fail_data", first_fail_data, m_ff_data);
`endif
            if (start && !m_busy) begin
                for (int i = 0; i < 16; i++) written[i] = 0;
                wr_cnt = 0;
                dup_cnt = 0;
            end
            if (imem_we === 1'b1) begin
                if (written[imem_addr]) dup_cnt++;
                written[imem_addr] = 1;
                shadow[imem_addr] = imem_wdata;
                wr_cnt++;
            end
        end
    end

    // One full test run; src_mode<0 toggles src_valid, mis_pct<0 uses mis_mask per compare index.
    task automatic do_run(input int plen, input int clen, input int src_mode, input int exp_pct,
                          input int mis_pct, input logic [31:0] mis_mask, input int abort_at,
                          input bit fixed_data);
        int eff_len, words, lc, cyc, cmps, errs;
        bit tmo, mis;
        eff_len = (plen > 16) ? 16 : plen;
        prog_len = (AW+1)'(plen);
        chk_len = 16'(clen);
        start = 1;
        step();
        start = 0;
        m_idle();
        m_busy = 1;
        words = 0;
        lc = 0;
        while (words < eff_len && lc < 2000) begin
            src_valid = (src_mode < 0) ? (lc % 2 == 0) : ($urandom_range(1, 100) <= src_mode);
            src_data = fixed_data ? (32'hC0DE_0000 + words) : $urandom;
            start = ($urandom_range(0, 3) == 0);
            m_src_ready = 1;
            m_imem_we = src_valid;
            m_imem_addr = AW'(words);
            m_imem_wdata = src_valid ? src_data : '0;
            step();
            if (src_valid) words++;
            lc++;
        end
        if (words < eff_len) check("load_budget", words, eff_len);
        src_valid = 0;
        m_src_ready = 0; m_imem_we = 0; m_imem_wdata = '0;
        for (int h = 0; h < HOLD; h++) begin
            start = ($urandom_range(0, 3) == 0);
            step();
        end
        cyc = 0; cmps = 0; errs = 0; tmo = 0;
        forever begin
            if (cyc == abort_at) begin
                reset = 0;
                exp_valid = 0;
                start = 0;
                m_idle();
                #1;
                check("abort_busy", busy, 0);
                check("abort_cycle_count", cycle_count, 0);
                check("abort_cpu_reset", cpu_reset, 1);
                step();
                reset = 1;
                step();
                return;
            end
            wb_out = $urandom;
            exp_valid = ($urandom_range(1, 100) <= exp_pct);
            mis = (mis_pct < 0) ? mis_mask[cmps % 32] : ($urandom_range(1, 100) <= mis_pct);
            exp_data = mis ? (wb_out ^ (32'h1 << $urandom_range(0, 31))) : wb_out;
            start = ($urandom_range(0, 3) == 0);
            m_cpu_reset = 0; m_exp_ready = 1;
            m_cyc = 16'(cyc); m_err = 16'(errs);
            step();
            cyc++;
            if (exp_valid) begin
`ifdef RISC_TEST_SEQ_TRACE_EN
                if (mis && !m_ff_cap) begin
                    m_ff_cap = 1; m_ff_idx = 16'(cmps); m_ff_data = wb_out;
                end
`endif
                cmps++;
                if (mis && errs < 65535) errs++;
            end
            if (clen == 0 || (exp_valid && cmps == clen)) break;
            if (cyc == TMO) begin
                tmo = 1;
                break;
            end
        end
        exp_valid = 0;
        start = 0;
        m_cpu_reset = 1; m_exp_ready = 0; m_busy = 0; m_done = 1;
        m_cyc = 16'(cyc); m_err = 16'(errs); m_timeout = tmo;
        m_pass = (errs == 0) && !tmo;
        step();
        step();
    endtask

    initial begin
        reset = 0; start = 0; src_valid = 0; exp_valid = 0;
        prog_len = '0; chk_len = '0; src_data = '0; wb_out = '0; exp_data = '0;
        m_idle();
        chk_en = 1;
        step();
        step();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_busy", busy, 0);
        reset = 1;
        step();

        do_run(3, 4, 100, 100, 0, 32'h0, -1, 1);
        check("load_word0", shadow[0], 32'hC0DE_0000);
        check("load_word1", shadow[1], 32'hC0DE_0001);
        check("load_word2", shadow[2], 32'hC0DE_0002);
        check("load_writes", wr_cnt, 3);
        check("clean_pass", pass, 1);
        check("clean_cycles", cycle_count, 4);

        do_run(3, 4, 100, 100, -1, 32'b1010, -1, 0);
        check("mis_err_count", err_count, 2);
        check("mis_pass", pass, 0);
`ifdef RISC_TEST_SEQ_TRACE_EN
        check("mis_first_idx", first_fail_idx, 1);
`endif

        do_run(3, 20, 100, 0, 0, 32'h0, -1, 0);
        check("tmo_flag", timeout, 1);
        check("tmo_cycles", cycle_count, 8);
        check("tmo_pass", pass, 0);

        do_run(9, 2, -1, 100, 0, 32'h0, -1, 1);
        check("toggle_writes", wr_cnt, 9);
        check("toggle_dups", dup_cnt, 0);
        check("toggle_word8", shadow[8], 32'hC0DE_0008);

        do_run(2, 8, 100, 100, 0, 32'h0, -1, 0);
        check("race_timeout", timeout, 0);
        check("race_pass", pass, 1);

        do_run(0, 0, 100, 0, 0, 32'h0, -1, 0);
        check("zero_cycles", cycle_count, 1);
        check("zero_writes", wr_cnt, 0);

        do_run(20, 1, 100, 100, 0, 32'h0, -1, 0);
        check("clamp_writes", wr_cnt, 16);
        check("clamp_dups", dup_cnt, 0);

        do_run(2, 10, 100, 100, 0, 32'h0, 5, 0);
        check("abort_idle_cpu_reset", cpu_reset, 1);
        check("abort_idle_err", err_count, 0);

        for (int r = 0; r < 40; r++) begin
            do_run($urandom_range(0, 20), $urandom_range(0, 10), $urandom_range(30, 100),
                   ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(30, 100),
                   $urandom_range(0, 50), 32'h0,
                   ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : -1, 0);
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
